carbondma_desc_fetch: RTL

Descriptor reader for CarbonDMA turbo submits. It accepts a descriptor pointer, reads the 32-byte DESC_V1 record (8 little-endian 32-bit words) over a single-outstanding memory read port, then validates and unpacks the fields. It presents one decoded descriptor, with a turbo status code, to the channel engine over a valid/ready handshake.

---
 rtl/carbondma_desc_fetch.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/carbondma_desc_fetch.sv
// carbondma_desc_fetch
//   Reads one 32-byte DESC_V1 record (8 little-endian words) through a
//   single-outstanding memory read port, validates it and presents the
//   decoded descriptor plus a status code on a valid/ready interface.
//
//   Build option: define CARBONDMA_DESC_STATS_EN to generate the saturating
//   OK / error descriptor counters. Without it both counter ports read 0.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for a submit, sub_ready high
//   REQ     | read request for word idx presented, address held
//   WAIT    | request accepted, waiting for its response
//   OUT     | decoded descriptor presented until desc_ready

module carbondma_desc_fetch #(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sub_valid_i,
    output logic              sub_ready_o,
    input  logic [ADDR_W-1:0] sub_addr_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [31:0]       mem_rsp_data_i,
    input  logic              mem_rsp_err_i,
    output logic              desc_valid_o,
    input  logic              desc_ready_i,
    output logic [63:0]       desc_src_o,
    output logic [63:0]       desc_dst_o,
    output logic [LEN_W-1:0]  desc_len_o,
    output logic              desc_fill_o,
    output logic [31:0]       desc_fill_val_o,
    output logic [31:0]       desc_attr_o,
    output logic [2:0]        desc_status_o,
    output logic              busy_o,
    output logic [15:0]       stat_ok_cnt_o,
    output logic [15:0]       stat_err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    localparam logic [2:0] STATUS_OK          = 3'd0;
    localparam logic [2:0] STATUS_INVALID     = 3'd1;
    localparam logic [2:0] STATUS_FAULT       = 3'd2;
    localparam logic [2:0] STATUS_UNSUPPORTED = 3'd4;

    // Record word slots
    localparam int W_SRC_LO = 0;
    localparam int W_SRC_HI = 1;
    localparam int W_DST_LO = 2;
    localparam int W_DST_HI = 3;
    localparam int W_LEN    = 4;
    localparam int W_FLAGS  = 5;
    localparam int W_FILL   = 6;
    localparam int W_ATTR   = 7;

    // Highest base whose 32-byte record does not wrap: 2^ADDR_W - 32
    localparam logic [ADDR_W-1:0] ADDR_LAST_BASE = ~ADDR_W'(31);
    localparam bit                NARROW_ADDR    = (ADDR_W == 32);

    state_e            state_q;
    logic [2:0]        idx_q;
    logic [2:0]        idx_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] next_addr_d;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_req_addr_q;
    logic              desc_valid_q;
    logic [2:0]        status_q;
    logic [2:0]        final_status_d;
    logic              sub_ready_q;
    logic              busy_q;
    logic [31:0]       words_q [8];
    logic              sub_bad;
    logic              len_hi_nz;

    assign idx_d       = idx_q + 3'd1;
    assign next_addr_d = base_q + {{(ADDR_W-5){1'b0}}, idx_d, 2'b00};
    assign sub_bad     = (sub_addr_i[1:0] != 2'b00) || (sub_addr_i > ADDR_LAST_BASE);
    // Any LEN bit above the output width makes the length unrepresentable
    assign len_hi_nz   = |(words_q[W_LEN] >> LEN_W);

    // Validate the fully fetched record in priority order
    always_comb begin
        final_status_d = STATUS_OK;
        if (words_q[W_LEN] == 32'd0) begin
            final_status_d = STATUS_INVALID;
        end else if (len_hi_nz) begin
            final_status_d = STATUS_INVALID;
        end else if (words_q[W_FLAGS][31:1] != 31'd0) begin
            final_status_d = STATUS_UNSUPPORTED;
        end else if (NARROW_ADDR &&
                     ((words_q[W_SRC_HI] != 32'd0) || (words_q[W_DST_HI] != 32'd0))) begin
            final_status_d = STATUS_INVALID;
        end
    end

    // Fetch sequencer: one request outstanding, registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            idx_q           <= 3'd0;
            base_q          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            desc_valid_q    <= 1'b0;
            status_q        <= STATUS_OK;
            sub_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sub_valid_i) begin
                        base_q      <= sub_addr_i;
                        idx_q       <= 3'd0;
                        sub_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        // Words not fetched this time must read back as 0
                        for (int i = 0; i < 8; i++) begin
                            words_q[i] <= '0;
                        end
                        if (sub_bad) begin
                            status_q     <= STATUS_INVALID;
                            desc_valid_q <= 1'b1;
                            state_q      <= ST_OUT;
                        end else begin
                            status_q        <= STATUS_OK;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= sub_addr_i;
                            state_q         <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        if (mem_rsp_err_i) begin
                            status_q     <= STATUS_FAULT;
                            desc_valid_q <= 1'b1;
                            state_q      <= ST_OUT;
                        end else begin
                            words_q[idx_q] <= mem_rsp_data_i;
                            if (idx_q == 3'd7) begin
                                status_q     <= final_status_d;
                                desc_valid_q <= 1'b1;
                                state_q      <= ST_OUT;
                            end else begin
                                idx_q           <= idx_d;
                                mem_req_addr_q  <= next_addr_d;
                                mem_req_valid_q <= 1'b1;
                                state_q         <= ST_REQ;
                            end
                        end
                    end
                end
                ST_OUT: begin
                    if (desc_ready_i) begin
                        desc_valid_q <= 1'b0;
                        sub_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sub_ready_o     = sub_ready_q;
    assign busy_o          = busy_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_req_addr_q;
    assign desc_valid_o    = desc_valid_q;
    assign desc_status_o   = status_q;
    assign desc_src_o      = {words_q[W_SRC_HI], words_q[W_SRC_LO]};
    assign desc_dst_o      = {words_q[W_DST_HI], words_q[W_DST_LO]};
    assign desc_len_o      = words_q[W_LEN][LEN_W-1:0];
    assign desc_fill_o     = words_q[W_FLAGS][0];
    assign desc_fill_val_o = words_q[W_FILL];
    assign desc_attr_o     = words_q[W_ATTR];

`ifdef CARBONDMA_DESC_STATS_EN
    logic [15:0] stat_ok_q;
    logic [15:0] stat_err_q;
    logic        out_hs;

    assign out_hs = desc_valid_q && desc_ready_i;

    // Saturating completion counters, split by status
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_ok_q  <= 16'd0;
            stat_err_q <= 16'd0;
        end else if (out_hs) begin
            if (status_q == STATUS_OK) begin
                if (stat_ok_q != 16'hFFFF) begin
                    stat_ok_q <= stat_ok_q + 16'd1;
                end
            end else begin
                if (stat_err_q != 16'hFFFF) begin
                    stat_err_q <= stat_err_q + 16'd1;
                end
            end
        end
    end

    assign stat_ok_cnt_o  = stat_ok_q;
    assign stat_err_cnt_o = stat_err_q;
`else
    assign stat_ok_cnt_o  = 16'd0;
    assign stat_err_cnt_o = 16'd0;
`endif

endmodule
